// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int W = 8;                        // instruction and address width
    localparam logic [W-1:0] RESET_PC_DEF = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // One buffered instruction together with the address it came from.
    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] instr;
    } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer. Entry e0 is always the head.
// A push and pop in the same cycle on an empty buffer is a pass-through:
// the arriving word is consumed directly and nothing is stored.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  entry_t     din,
    input  logic       pop,
    input  logic       flush,
    output entry_t     head,
    output logic [1:0] count
);

    entry_t e0, e1;

    // Storage and occupancy update; flush wins over push/pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= 2'd0;
            e0    <= '0;
            e1    <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= din;
                    else               e1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        e0 <= e1;
                        e1 <= din;
                    end else if (count == 2'd1) begin
                        e0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = (count != 2'd0) ? e0 : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues single-byte reads, buffers up to two
// responses and hands them to the controller. The response arriving this
// cycle is visible on IR immediately when the buffer is empty.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int           DEPTH    = 2
) (
    input  logic         clock,
    input  logic         reset,
    output logic [W-1:0] MemAddr,
    output logic         MemRead,
    input  logic [W-1:0] MemData,
    output logic [W-1:0] IR,
    output logic         IRvalid,
    input  logic         IRready,
    output logic [W-1:0] PCout,
    input  logic         Redirect,
    input  logic [W-1:0] RedirectPC,
    input  logic         Halt,
    output logic         IncCount
);

    state_t       state, state_nx;
    logic [W-1:0] pc, infl_pc;
    logic         infl;
    logic         resp_ok, handoff, space;
    logic [1:0]   count;
    entry_t       head, resp, ir_ent;

    fetch_fifo u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (resp_ok),
        .din   (resp),
        .pop   (handoff),
        .flush (Redirect),
        .head  (head),
        .count (count)
    );

    // Next state, handoff, read issue and output muxing.
    always_comb begin
        state_nx = state;
        resp     = '{pc: infl_pc, instr: MemData};
        // A response is kept only if nobody is flushing the pipe this cycle.
        resp_ok  = infl && (state == FETCH) && !Redirect;
        IRvalid  = (count != 2'd0) || resp_ok;
        ir_ent   = (count != 2'd0) ? head : (resp_ok ? resp : '0);
        handoff  = IRvalid && IRready && !Redirect;
        // Free space counts the entry popping this cycle.
        space    = ({1'b0, count} + {2'b0, infl}) < (3'(DEPTH) + {2'b0, handoff});
        MemRead  = (state == FETCH) && !Halt && space;
        MemAddr  = MemRead ? pc : '0;
        IR       = ir_ent.instr;
        PCout    = ir_ent.pc;
        IncCount = handoff;
        unique case (state)
            IDLE:    state_nx = FETCH;
            FETCH:   state_nx = FETCH;
            FLUSH:   state_nx = FETCH;
            default: state_nx = IDLE;
        endcase
        if (Redirect) state_nx = FLUSH;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // PC and the single outstanding-read tracker.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            infl    <= 1'b0;
            infl_pc <= '0;
        end else begin
            infl    <= MemRead;
            infl_pc <= pc;
            if (Redirect)     pc <= RedirectPC;
            else if (MemRead) pc <= pc + 8'd1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed phases, then random traffic,
// compared each cycle against a queue-based model of the fetch rules.
module tb_fetch_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] MemAddr, MemData, IR, PCout, RedirectPC;
    logic       MemRead, IRvalid, IRready, Redirect, Halt, IncCount;
    logic [7:0] fe_addr, fe_data, fe_ir, fe_pc;
    logic       fe_rd, fe_irv, fe_inc;

    logic [7:0] mem [256];
    int total = 0;
    int bad   = 0;
    int phase = 0;

    always #5 clock = ~clock;

    initial for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);

    fetch_unit #(.RESET_PC(8'h00)) dut (
        .clock(clock), .reset(reset), .MemAddr(MemAddr), .MemRead(MemRead),
        .MemData(MemData), .IR(IR), .IRvalid(IRvalid), .IRready(IRready),
        .PCout(PCout), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .Halt(Halt), .IncCount(IncCount)
    );

    fetch_unit #(.RESET_PC(8'hFE)) dut_fe (
        .clock(clock), .reset(reset), .MemAddr(fe_addr), .MemRead(fe_rd),
        .MemData(fe_data), .IR(fe_ir), .IRvalid(fe_irv), .IRready(IRready),
        .PCout(fe_pc), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .Halt(Halt), .IncCount(fe_inc)
    );

    // Synchronous instruction memory; garbage on the bus when not reading.
    always @(posedge clock) begin
        MemData <= MemRead ? mem[MemAddr] : 8'($urandom);
        fe_data <= fe_rd ? mem[fe_addr] : 8'($urandom);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model state: buffered entries, pc, outstanding read, mode (0 idle, 1 fetch, 2 flush).
    logic [15:0] q[$];
    logic [15:0] view[$];
    logic [15:0] hd;
    logic [7:0]  m_pc, m_ipc, a, fe_exp;
    bit          m_infl, arr, hand, rd;
    int          m_mode, cyc, last_phase = -1, ph_start = 0, rel;

    initial forever begin
        @(negedge clock or negedge reset);
        if (!reset) begin
            #1;
            chk("rst_memread", MemRead, 0);
            chk("rst_memaddr", MemAddr, 0);
            chk("rst_irvalid", IRvalid, 0);
            chk("rst_inccount", IncCount, 0);
            chk("rst_ir", IR, 0);
            chk("rst_pcout", PCout, 0);
            q.delete();
            m_mode = 0; m_pc = 8'h00; m_infl = 0; cyc = 0;
        end else begin
            if (phase != last_phase) begin last_phase = phase; ph_start = cyc; end
            rel  = cyc - ph_start;
            arr  = m_infl && m_mode == 1 && !Redirect;
            view = q;
            if (arr) view.push_back({m_ipc, mem[m_ipc]});
            hd   = (view.size() > 0) ? view[0] : 16'h0;
            hand = view.size() > 0 && IRready && !Redirect;
            rd   = m_mode == 1 && !Halt && (q.size() + int'(m_infl) - int'(hand) < 2);
            chk("irvalid", IRvalid, int'(view.size() > 0));
            chk("ir", IR, hd[7:0]);
            chk("pcout", PCout, hd[15:8]);
            chk("inccount", IncCount, hand);
            chk("memread", MemRead, rd);
            chk("memaddr", MemAddr, rd ? m_pc : 8'h00);

            // Hand-computed expectations for the directed phases.
            if ((phase == 1 || phase == 6) && cyc == 0) chk("idle_noread", MemRead, 0);
            if ((phase == 1 || phase == 6) && cyc == 1) chk("first_addr", {MemRead, MemAddr}, {1'b1, 8'h00});
            if ((phase == 1 || phase == 6) && cyc == 2) begin
                chk("first_ir", {IRvalid, PCout, IR}, {1'b1, 8'h00, 8'h10});
                chk("first_inc", IncCount, 1);
            end
            if ((phase == 1 || phase == 6) && cyc == 3) chk("second_ir", {PCout, IR}, {8'h01, 8'h11});
            if (phase == 1 && cyc >= 1 && cyc <= 4) begin
                fe_exp = 8'hFE + 8'(cyc - 1);
                chk("wrap_addr", {fe_rd, fe_addr}, {1'b1, fe_exp});
            end
            if (phase == 1 && cyc == 2) chk("wrap_ir", {fe_irv, fe_inc, fe_pc, fe_ir}, {2'b11, 8'hFE, 8'h0E});
            if (phase == 2 && rel == 4) chk("stall_full", {IRvalid, MemRead}, 2'b10);
            if (phase == 3 && rel == 0) chk("redir_noinc", IncCount, 0);
            if (phase == 3 && rel == 1) chk("redir_gap", {MemRead, IRvalid}, 2'b00);
            if (phase == 3 && rel == 2) chk("redir_addr", {MemRead, MemAddr}, {1'b1, 8'h40});
            if (phase == 3 && rel == 3) chk("redir_ir", {IRvalid, PCout, IR}, {1'b1, 8'h40, 8'h50});
            if (phase == 4 && rel == 0) chk("halt_last", {IRvalid, IncCount, MemRead}, 3'b110);
            if (phase == 4 && rel == 2) chk("halt_idle", {IRvalid, MemRead}, 2'b00);

            // Advance the model across the coming rising edge.
            a = m_pc;
            if (Redirect) begin
                q.delete();
                m_pc   = RedirectPC;
                m_mode = 2;
            end else begin
                if (hand) void'(view.pop_front());
                q = view;
                if (rd) m_pc = m_pc + 8'd1;
                m_mode = 1;
            end
            m_infl = rd;
            m_ipc  = a;
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; IRready = 1'b0; Halt = 1'b0; Redirect = 1'b0; RedirectPC = 8'h00;
        repeat (3) tick();
        phase = 1; IRready = 1'b1; reset = 1'b1;
        repeat (8) tick();
        phase = 2; IRready = 1'b0;
        repeat (5) tick();
        IRready = 1'b1;
        repeat (6) tick();
        phase = 3; Redirect = 1'b1; RedirectPC = 8'h40;
        tick();
        Redirect = 1'b0;
        repeat (8) tick();
        phase = 4; Halt = 1'b1;
        repeat (4) tick();
        Halt = 1'b0;
        repeat (4) tick();
        phase = 5;
        repeat (1500) begin
            IRready    = ($urandom % 4) != 0;
            Halt       = ($urandom % 6) == 0;
            Redirect   = ($urandom % 16) == 0;
            RedirectPC = ($urandom % 2) ? 8'hFD : 8'($urandom);
            if (($urandom % 250) == 0) begin
                reset = 1'b0;
                repeat (1 + $urandom % 2) tick();
                reset = 1'b1;
            end
            tick();
        end
        phase = 6; IRready = 1'b1; Halt = 1'b0; Redirect = 1'b0; reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (8) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
